// File: rtl/countdown_timer_8bit.sv
// Loadable down-counter with one-shot / auto-reload modes and a one-cycle underflow pulse.
// Latency: every control input takes effect on the next rising edge; no combinational input-to-output path.
// Backpressure: none. en gates counting; with en low in RUN the count simply holds.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   load         capture load_val into reload register and count; forces IDLE
//   load_val     value captured on load
//   start        begin (or restart) countdown from the reload register
//   stop         abort a running countdown; count holds
//   en           tick enable; counting happens only in RUN on en=1 cycles
//   auto_reload  1: periodic, 0: one-shot (sampled on the terminal tick only)
//   count        current count (registered)
//   underflow    registered one-cycle pulse on each terminal tick
//   busy         high while in RUN
//   done         high while in DONE (one-shot expired)
module countdown_timer_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] count_q,     count_d;
  logic [WIDTH-1:0] reload_q,    reload_d;
  logic             underflow_q, underflow_d;

  // Terminal tick: an enabled cycle in RUN that finds the count already at zero.
  // Zero is handled here rather than by letting the decrement wrap.
  logic terminal_tick;
  assign terminal_tick = (state_q == RUN) && en && (count_q == ZERO);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= ZERO;
      reload_q    <= ZERO;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  // Next-state logic. Priority: load > stop > start > counting.
  // stop wins over start even outside RUN; it merely has nothing to abort there.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start) begin
      // A start coinciding with a terminal tick restarts and suppresses the pulse.
      count_d = reload_q;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (terminal_tick) begin
            underflow_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end else if (en) begin
            count_d = count_q - ONE;
          end
        end
        IDLE, DONE: begin
          // Count holds; en is ignored.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decoded straight from registered state.
  assign count     = count_q;
  assign underflow = underflow_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// Bench for countdown_timer_8bit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_countdown_timer_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] count;
  logic       underflow;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;
  bit check_on = 1'b0;

  countdown_timer_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .en(en), .auto_reload(auto_reload),
    .count(count), .underflow(underflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: a remaining-tick value, a reload value and two flags
  // (running / expired) describing what the timer is doing.
  int  m_remaining = 0;
  int  m_reload    = 0;
  bit  m_running   = 1'b0;
  bit  m_expired   = 1'b0;
  bit  m_pulse     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, then compare shortly after.
  always @(posedge clk) begin
    m_pulse = 1'b0;
    if (rst) begin
      m_remaining = 0; m_reload = 0; m_running = 0; m_expired = 0;
    end else if (load) begin
      m_remaining = int'(load_val); m_reload = int'(load_val);
      m_running = 0; m_expired = 0;
    end else if (stop) begin
      m_running = 0;
    end else if (start) begin
      m_remaining = m_reload; m_running = 1; m_expired = 0;
    end else if (m_running && en) begin
      if (m_remaining > 0) begin
        m_remaining = m_remaining - 1;
      end else begin
        m_pulse = 1'b1;
        if (auto_reload) m_remaining = m_reload;
        else begin m_running = 0; m_expired = 1; end
      end
    end
    #1;
    if (check_on) begin
      check("model_count", int'(count), m_remaining);
      check("model_underflow", int'(underflow), int'(m_pulse));
      check("model_busy", int'(busy), int'(m_running));
      check("model_done", int'(done), int'(m_expired));
    end
  end

  // Apply one cycle of inputs (called at a negedge); returns at the next negedge.
  task automatic step(input bit r, input bit ld, input logic [7:0] lv,
                      input bit st, input bit sp, input bit e, input bit ar);
    rst = r; load = ld; load_val = lv; start = st; stop = sp; en = e; auto_reload = ar;
    @(negedge clk);
  endtask

  task automatic idle_in(input bit e, input bit ar);
    step(0, 0, 8'd0, 0, 0, e, ar);
  endtask

  int pulses;
  int done_seen;

  initial begin
    @(negedge clk);
    step(1, 0, 8'd0, 0, 0, 0, 0);
    check_on = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_flags", int'({underflow, busy, done}), 0);

    // Reset during RUN clears reload too
    step(0, 1, 8'd5, 0, 0, 0, 0);
    step(0, 0, 8'd0, 1, 0, 1, 0);
    idle_in(1, 0);
    idle_in(1, 0);
    check("pre_rst_count", int'(count), 3);
    step(1, 0, 8'd0, 0, 0, 1, 0);
    step(1, 0, 8'd0, 0, 0, 1, 0);
    check("rst_run_count", int'(count), 0);
    check("rst_run_flags", int'({underflow, busy, done}), 0);
    step(0, 0, 8'd0, 1, 0, 0, 0);
    check("rst_reload_zero", int'(count), 0);
    check("rst_start_busy", int'(busy), 1);
    idle_in(1, 0);
    check("rst_zero_underflow", int'(underflow), 1);

    // One-shot, load 5
    step(0, 1, 8'd5, 0, 0, 0, 0);
    check("os_load_busy", int'(busy), 0);
    step(0, 0, 8'd0, 1, 0, 1, 0);
    check("os_start_count", int'(count), 5);
    for (int i = 4; i >= 0; i--) begin
      idle_in(1, 0);
      check("os_count_seq", int'(count), i);
      check("os_no_uf", int'(underflow), 0);
    end
    idle_in(1, 0);
    check("os_uf", int'(underflow), 1);
    check("os_done", int'(done), 1);
    check("os_busy", int'(busy), 0);
    idle_in(1, 0);
    check("os_uf_one_cycle", int'(underflow), 0);
    check("os_hold_zero", int'(count), 0);
    check("os_done_hold", int'(done), 1);

    // Periodic, load 3
    step(0, 1, 8'd3, 0, 0, 0, 1);
    step(0, 0, 8'd0, 1, 0, 1, 1);
    pulses = 0; done_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      idle_in(1, 1);
      pulses += int'(underflow);
      done_seen += int'(done);
      if (i == 4) check("per_reload_count", int'(count), 3);
    end
    check("per_pulses", pulses, 3);
    check("per_no_done", done_seen, 0);

    // Gated enable, load 2
    step(0, 1, 8'd2, 0, 0, 0, 0);
    step(0, 0, 8'd0, 1, 0, 0, 0);
    idle_in(1, 0); check("gate_e1", int'(count), 1);
    idle_in(0, 0); check("gate_e0", int'(count), 1);
    idle_in(1, 0); check("gate_e1b", int'(count), 0);
    idle_in(0, 0); check("gate_no_uf", int'(underflow), 0);
    idle_in(1, 0); check("gate_uf", int'(underflow), 1);

    // Stop / restart / load+start
    step(0, 1, 8'd10, 0, 0, 0, 0);
    step(0, 0, 8'd0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) idle_in(1, 0);
    step(0, 0, 8'd0, 1, 1, 1, 0);
    check("stop_hold", int'(count), 4);
    check("stop_idle", int'(busy), 0);
    idle_in(1, 0);
    check("stop_hold2", int'(count), 4);
    step(0, 0, 8'd0, 1, 0, 1, 0);
    check("restart_count", int'(count), 10);
    step(0, 1, 8'd7, 1, 0, 1, 0);
    check("ldst_count", int'(count), 7);
    check("ldst_busy", int'(busy), 0);

    // Start on terminal tick
    step(0, 1, 8'd1, 0, 0, 0, 1);
    step(0, 0, 8'd0, 1, 0, 1, 1);
    idle_in(1, 1);
    step(0, 0, 8'd0, 1, 0, 1, 1);
    check("tt_start_no_uf", int'(underflow), 0);
    check("tt_start_count", int'(count), 1);

    // Reload 0 periodic: pulse every enabled cycle
    step(0, 1, 8'd0, 0, 0, 0, 1);
    step(0, 0, 8'd0, 1, 0, 1, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin idle_in(1, 1); pulses += int'(underflow); end
    check("zero_pulses", pulses, 5);

    // Reload 255: first underflow after 256 enabled edges
    step(0, 1, 8'd255, 0, 0, 0, 0);
    step(0, 0, 8'd0, 1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 255; i++) begin idle_in(1, 0); pulses += int'(underflow); end
    check("max_no_early_uf", pulses, 0);
    check("max_count_zero", int'(count), 0);
    idle_in(1, 0);
    check("max_uf", int'(underflow), 1);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), lv,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    idle_in(0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
